divu_32bit: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_1_bit.sv | 24 ++
 rtl/divu_32bit_div_step.sv | 46 ++++
 rtl/divu_32bit.sv | 122 ++++++++++++
 tb/tb_divu_32bit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: shared ALU datapath constants and divider state encoding   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_1_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_1_bit: one-bit add/subtract slice (i_sub inverts the b operand) |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_1_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  logic i_sub,
  output logic o_sum,
  output logic o_cout
);

  logic w_b;
  logic w_p;

  assign w_b    = i_b ^ i_sub;
  assign w_p    = i_a ^ w_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_cin & w_p);

endmodule
`default_nettype wire

// File: rtl/divu_32bit_div_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_step: one restoring-division iteration (shift, trial, restore)  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH+1:0] w_carry;

  // Shifted remainder is kept at WIDTH+1 bits so a divisor with MSB set cannot overflow.
  assign w_shift    = {i_rem, i_q_msb};
  assign w_d_ext    = {1'b0, i_divisor};
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_slice
      alu_1_bit u_slice (
        .i_a    (w_shift[i]),
        .i_b    (w_d_ext[i]),
        .i_cin  (w_carry[i]),
        .i_sub  (1'b1),
        .o_sum  (w_trial[i]),
        .o_cout (w_carry[i+1])
      );
    end
  endgenerate

  // A non-negative trial and a no-borrow carry-out coincide for these operand ranges.
  assign o_q_bit = ~w_trial[WIDTH] & w_carry[WIDTH+1];
  assign o_rem   = o_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/divu_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | divu_32bit: sequential unsigned restoring divider, one bit/clock    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module divu_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t r_state;
  div_state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_q_bit;
  logic             w_last;
  logic             w_div_zero;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_r),
    .i_q_msb   (r_q[WIDTH-1]),
    .i_divisor (r_d),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  assign w_q_next   = {r_q[WIDTH-2:0], w_q_bit};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div_zero = (divisor == '0);
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result registers only change when an operation completes, so they hold across a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_div_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_d   <= divisor;
              r_r   <= '0;
              r_cnt <= '0;
            end
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            quotient    <= w_q_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divu_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_divu_32bit: directed vector bench for the restoring divider      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_divu_32bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int tests = 0;
  int fails = 0;

  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;
  logic        prev_z = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs [11];

  divu_32bit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after the sampling edge until done is seen, plus busy cycles on the way.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic z);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, z});
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int nbusy;
    launch(v.a, v.b);
    if (!done) begin
      check_result("hold", prev_q, prev_r, prev_z);
    end
    wait_done(lat, nbusy);
    check_result("result", v.q, v.r, v.z);
    chk("latency", lat, (v.b == 32'd0) ? 32'd0 : 32'd32);
    chk("busy_cycles", nbusy, (v.b == 32'd0) ? 32'd0 : 32'd32);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    check_result("post_hold", v.q, v.r, v.z);
    prev_q = v.q;
    prev_r = v.r;
    prev_z = v.z;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int nbusy;
    int ndone;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[2]  = '{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000,  1'b0};
    vecs[3]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[5]  = '{32'd10,         32'd10,         32'd1,          32'd0,          1'b0};
    vecs[6]  = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0};
    vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[8]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
    vecs[9]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[10] = '{32'h1234_5678,  32'h1234,       32'h0001_0004,  32'h0000_0DA8,  1'b0};

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_result("reset", 32'd0, 32'd0, 1'b0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
    end

    // A start pulse with new operands mid-run must not disturb 1000/3.
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("ign_busy", {31'b0, busy}, 32'd1);
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("ign_latency", lat + 10, 32'd32);
    check_result("ign", 32'd333, 32'd1, 1'b0);
    @(negedge clk);

    // Reset mid-run aborts with no done pulse.
    launch(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_result("abort", 32'd0, 32'd0, 1'b0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    run_vec('{32'd50, 32'd8, 32'd6, 32'd2, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
